// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 key event decoder
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_t;

  // rep stands in for the repeat flag, which cannot be a field name
  typedef struct packed {
    logic       rep;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_rx.sv
// rtl/ps2_key_event_decoder_rx.sv - oversampled PS/2 frame receiver with parity and timeout checks
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   data_s;
  logic [3:0]             bit_cnt;
  logic [9:0]             shreg;
  logic [TW-1:0]          tmo_cnt;
  logic                   frame_ok;

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  // shreg[0]=start, shreg[8:1]=data, shreg[9]=parity; data_s is the stop bit
  assign frame_ok = ~shreg[0] & data_s & (^shreg[9:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync    <= '1;
      data_sync   <= '1;
      clk_prev    <= 1'b1;
      bit_cnt     <= '0;
      shreg       <= '0;
      tmo_cnt     <= '0;
      rx_byte     <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync   <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev    <= clk_sync[SYNC_STAGES-1];
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt     <= '0;
          rx_byte     <= shreg[8:1];
          byte_strobe <= frame_ok;
          frame_err   <= ~frame_ok;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {data_s, shreg[9:1]};
        end
      end else if (bit_cnt == 4'd0) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_cnt   <= '0;
        bit_cnt   <= '0;
        frame_err <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// rtl/ps2_key_event_decoder.sv - PS/2 scan-code decoder folding E0/F0 prefixes into buffered key events
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_repeat,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       byte_strobe;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_strobe(byte_strobe),
    .frame_err  (frame_err)
  );

  dec_state_t state_q, state_d;
  logic       emit, emit_ext, emit_brk;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (frame_err) begin
      state_d = IDLE;
    end else if (byte_strobe) begin
      if (rx_byte == PS2_PFX_EXT) begin
        state_d = (state_q == IDLE || state_q == EXT) ? EXT : EXT_BRK;
      end else if (rx_byte == PS2_PFX_BRK) begin
        state_d = (state_q == IDLE || state_q == BRK) ? BRK : EXT_BRK;
      end else begin
        emit     = 1'b1;
        emit_ext = (state_q == EXT) || (state_q == EXT_BRK);
        emit_brk = (state_q == BRK) || (state_q == EXT_BRK);
        state_d  = IDLE;
      end
    end
  end

  logic       held_valid, held_ext;
  logic [7:0] held_code;
  logic       held_match;
  logic       push_valid;
  key_event_t push_ev;

  assign held_match = held_valid && (held_ext == emit_ext) && (held_code == rx_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= '0;
      push_valid <= 1'b0;
      push_ev    <= '0;
    end else begin
      push_valid <= emit;
      if (emit) begin
        push_ev <= '{rep: ~emit_brk & held_match, brk: emit_brk, ext: emit_ext, code: rx_byte};
        if (emit_brk) begin
          if (held_match) held_valid <= 1'b0;
        end else if (!held_match) begin
          held_valid <= 1'b1;
          held_ext   <= emit_ext;
          held_code  <= rx_byte;
        end
      end
    end
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match
  key_event_t        mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, do_pop, do_push;
  key_event_t        head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = ev_valid && ev_ready;
  assign do_push = push_valid && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_ev;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_valid && full && !do_pop) overflow <= 1'b1;
    end
  end

  assign ev_valid  = ~empty;
  assign ev_code   = head.code;
  assign ev_ext    = head.ext;
  assign ev_break  = head.brk;
  assign ev_repeat = head.rep;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb/tb_ps2_key_event_decoder.sv - scoreboard bench for ps2_key_event_decoder
module tb_ps2_key_event_decoder;

  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_valid, ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext, ev_break, ev_repeat, overflow, frame_err;

  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0;
  logic [10:0] sb [$];

  ps2_key_event_decoder #(
    .FIFO_DEPTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(400)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .ev_repeat(ev_repeat),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk, input logic rep);
    sb.push_back({rep, brk, ext, code});
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 ev_ready = r;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && frame_err) err_cnt++;
    if (!rst && ev_valid && ev_ready) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_event: observed %0h expected none", {ev_repeat, ev_break, ev_ext, ev_code});
      end
      if (sb.size() != 0) check("event", {21'd0, ev_repeat, ev_break, ev_ext, ev_code}, {21'd0, sb.pop_front()});
    end
  end

  initial begin
    ev_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_code", 32'(ev_code), 32'd0);

    // T1
    expect_ev(8'h1C, 0, 0, 0);
    send_byte(8'h1C, 0);
    wait_drain("t1");
    check("t1_err", 32'(err_cnt), 32'd0);

    // T2
    expect_ev(8'h1C, 0, 1, 0);
    send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    wait_drain("t2");

    // T3
    expect_ev(8'h75, 1, 1, 0);
    expect_ev(8'h75, 1, 0, 0);
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
    send_byte(8'hE0, 0); send_byte(8'h75, 0);
    wait_drain("t3");

    // T4
    expect_ev(8'h1C, 0, 0, 0);
    expect_ev(8'h1C, 0, 0, 1);
    expect_ev(8'h1C, 0, 0, 1);
    expect_ev(8'h1C, 0, 1, 0);
    expect_ev(8'h1C, 0, 0, 0);
    send_byte(8'h1C, 0); send_byte(8'h1C, 0); send_byte(8'h1C, 0);
    send_byte(8'hF0, 0); send_byte(8'h1C, 0); send_byte(8'h1C, 0);
    wait_drain("t4");
    check("t4_overflow", 32'(overflow), 32'd0);

    // T5
    set_ready(0);
    begin
      logic [7:0] codes [9];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
      for (int i = 0; i < 8; i++) begin
        expect_ev(codes[i], 0, 0, 0);
        send_byte(codes[i], 0);
      end
      @(negedge clk);
      check("t5_valid_full", 32'(ev_valid), 32'd1);
      check("t5_no_ovf_at_full", 32'(overflow), 32'd0);
      check("t5_head_hold", 32'(ev_code), 32'h15);
      send_byte(codes[8], 0);
      @(negedge clk);
      check("t5_overflow", 32'(overflow), 32'd1);
      check("t5_head_still", 32'(ev_code), 32'h15);
    end
    set_ready(1);
    wait_drain("t5");
    check("t5_empty", 32'(ev_valid), 32'd0);
    check("t5_ovf_sticky", 32'(overflow), 32'd1);

    // reset mid-prefix discards E0 and held key
    send_byte(8'hE0, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_overflow", 32'(overflow), 32'd0);
    check("rst2_valid", 32'(ev_valid), 32'd0);
    expect_ev(8'h44, 0, 0, 0);
    send_byte(8'h44, 0);
    wait_drain("rst2");

    // T6
    err_cnt = 0;
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 1);
    repeat (20) @(posedge clk);
    check("t6_err", 32'(err_cnt), 32'd1);
    check("t6_no_event", 32'(ev_valid), 32'd0);
    expect_ev(8'h1C, 0, 0, 0);
    send_byte(8'h1C, 0);
    wait_drain("t6");

    // timeout on a truncated frame, then a clean make of the held key
    err_cnt = 0;
    send_bits(11'b000_0000_0010, 3);
    repeat (500) @(posedge clk);
    check("tmo_err", 32'(err_cnt), 32'd1);
    expect_ev(8'h1C, 0, 0, 1);
    send_byte(8'h1C, 0);
    wait_drain("tmo");
    check("tmo_err_total", 32'(err_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
